// File: rtl/approx_mult_seq_if.sv
// rtl/approx_mult_seq_if.sv - operand/product handshake bundle for approx_mult_seq
// Purpose: carries both valid/ready handshakes and their data.
// Signals:
//   in_valid/in_ready   operand handshake (master -> slave / slave -> master)
//   a, b                NUM_BITS-wide operands
//   approx_en           1 = approximate mode, sampled with the operands
//   out_valid/out_ready product handshake (slave -> master / master -> slave)
//   y                   2*NUM_BITS-wide product
interface approx_mult_seq_if #(
  parameter int NUM_BITS = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_BITS-1:0]     a;
  logic [NUM_BITS-1:0]     b;
  logic                    approx_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*NUM_BITS-1:0]   y;

  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/approx_mult_seq.sv
// rtl/approx_mult_seq.sv - iterative shift-and-add multiplier with approximate low columns
// Purpose: one partial-product row per cycle; in approximate mode the low
//   APPROX_COLS product columns are OR-combined instead of added.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  approx_mult_seq_if.slave (operand and product handshakes)
module approx_mult_seq #(
  parameter int NUM_BITS    = 8,
  parameter int APPROX_COLS = 4,
  parameter int SIGNED      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  approx_mult_seq_if.slave      bus
);
  localparam int W  = 2 * NUM_BITS;
  localparam int JW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

  // Mask of the columns handled approximately; all-zero when APPROX_COLS=0.
  function automatic logic [W-1:0] lo_mask_f();
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) begin
      if (i < APPROX_COLS) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [W-1:0] LO_MASK = lo_mask_f();

  typedef enum logic [1:0] {IDLE, ACC, FIX, DONE} state_t;

  state_t                state_q;
  logic [NUM_BITS-1:0]   ua_q, ub_q;
  logic                  neg_q;
  logic                  approx_q;
  logic [W-1:0]          acc_q, lo_q;
  logic [JW-1:0]         j_q;
  logic                  in_ready_q, out_valid_q;
  logic [W-1:0]          y_q;

  logic                  a_neg, b_neg, last_row;
  logic [NUM_BITS-1:0]   ua_d, ub_d;
  logic [W-1:0]          row, acc_d, lo_d, mag, y_d;

  always_comb begin
    a_neg    = (SIGNED != 0) && bus.a[NUM_BITS-1];
    b_neg    = (SIGNED != 0) && bus.b[NUM_BITS-1];
    // Two's-complement negation; the most negative value maps onto 2^(N-1),
    // which is still representable as an N-bit unsigned magnitude.
    ua_d     = a_neg ? (~bus.a + 1'b1) : bus.a;
    ub_d     = b_neg ? (~bus.b + 1'b1) : bus.b;
    last_row = (j_q == JW'(NUM_BITS - 1));
    row      = ub_q[j_q] ? ({{NUM_BITS{1'b0}}, ua_q} << j_q) : '0;
    // Approximate rows contribute nothing to the low columns of the adder,
    // so no carry can ever leave them.
    acc_d    = acc_q + (approx_q ? (row & ~LO_MASK) : row);
    lo_d     = lo_q | (approx_q ? (row & LO_MASK) : '0);
    mag      = approx_q ? ((acc_q & ~LO_MASK) | lo_q) : acc_q;
    y_d      = neg_q ? (~mag + 1'b1) : mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ua_q        <= '0;
      ub_q        <= '0;
      neg_q       <= 1'b0;
      approx_q    <= 1'b0;
      acc_q       <= '0;
      lo_q        <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ua_q       <= ua_d;
            ub_q       <= ub_d;
            neg_q      <= a_neg ^ b_neg;
            approx_q   <= bus.approx_en;
            acc_q      <= '0;
            lo_q       <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          if (last_row) begin
            j_q     <= '0;
            state_q <= FIX;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        FIX: begin
          y_q         <= y_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
endmodule

// File: tb/tb_approx_mult_seq.sv
// tb/tb_approx_mult_seq.sv - directed and table-driven bench for approx_mult_seq
module tb_approx_mult_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  approx_mult_seq_if #(.NUM_BITS(8)) b0 ();
  approx_mult_seq_if #(.NUM_BITS(8)) b1 ();

  approx_mult_seq #(.NUM_BITS(8), .APPROX_COLS(4), .SIGNED(1)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  approx_mult_seq #(.NUM_BITS(8), .APPROX_COLS(0), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ap;
    logic [15:0] y;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      if (b0.in_ready === 1'b1 && b0.out_valid === 1'b1) begin
        bad++;
        $display("FAIL ready_valid_overlap actual=1 required=0");
      end
    end
  end

  task automatic drive_in(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic ap);
    b0.in_valid = v; b1.in_valid = v;
    b0.a = av;       b1.a = av;
    b0.b = bv;       b1.b = bv;
    b0.approx_en = ap; b1.approx_en = ap;
  endtask

  // Issues one operation to both instances and returns their products and the
  // number of cycles from the accept edge to the first cycle with out_valid.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ap,
                       output logic [15:0] y0, output logic [15:0] y1, output int lat);
    @(negedge clk);
    drive_in(1'b1, av, bv, ap);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, ~av, ~bv, ~ap);
    lat = 1;
    while (b0.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    y0 = b0.y;
    y1 = b1.y;
    b0.out_ready = 1'b1; b1.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0; b1.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[12];
    logic [15:0] y0, y1, yk, yhold;
    logic signed [7:0]  sa, sb;
    logic signed [15:0] ep;
    int          lat;
    logic        seen_valid;

    total = 0;
    bad   = 0;
    vecs[0]  = '{8'hF9, 8'h06, 1'b0, 16'hFFD6};
    vecs[1]  = '{8'h0F, 8'h0F, 1'b1, 16'h00BF};
    vecs[2]  = '{8'h0F, 8'h0F, 1'b0, 16'h00E1};
    vecs[3]  = '{8'hF1, 8'h0F, 1'b1, 16'hFF41};
    vecs[4]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[5]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[6]  = '{8'h00, 8'h7F, 1'b0, 16'h0000};
    vecs[7]  = '{8'h00, 8'h7F, 1'b1, 16'h0000};
    vecs[8]  = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};
    vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 16'h3EDF};
    vecs[10] = '{8'h7F, 8'h81, 1'b0, 16'hC0FF};
    vecs[11] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};

    rst = 1'b1;
    drive_in(1'b0, 8'h00, 8'h00, 1'b0);
    b0.out_ready = 1'b0; b1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'd0, b0.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, b0.out_valid}, 32'd0);
    check("reset_y", {16'd0, b0.y}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_in_ready", i), {31'd0, b0.in_ready}, 32'd1);
      do_op(vecs[i].a, vecs[i].b, vecs[i].ap, y0, y1, lat);
      check($sformatf("vec%0d_y", i), {16'd0, y0}, {16'd0, vecs[i].y});
      check($sformatf("vec%0d_latency", i), lat, 32'd10);
    end

    // Backpressure: product held, no new operand accepted while DONE.
    @(negedge clk);
    drive_in(1'b1, 8'hF9, 8'h06, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, 8'h00, 8'h00, 1'b0);
    lat = 1;
    while (b0.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_first_y", {16'd0, b0.y}, 32'h0000FFD6);
    yhold = b0.y;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) drive_in(1'b1, 8'h03, 8'h03, 1'b0);
      if (c == 3) drive_in(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", c), {31'd0, b0.out_valid}, 32'd1);
      check($sformatf("bp%0d_y", c), {16'd0, b0.y}, {16'd0, yhold});
      check($sformatf("bp%0d_in_ready", c), {31'd0, b0.in_ready}, 32'd0);
    end
    b0.out_ready = 1'b1; b1.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0; b1.out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, b0.in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, b0.out_valid}, 32'd0);
    repeat (12) @(negedge clk);
    check("bp_no_queued_op", {31'd0, b0.out_valid}, 32'd0);
    check("bp_y_unchanged", {16'd0, b0.y}, 32'h0000FFD6);

    // Reset mid-operation aborts it.
    @(negedge clk);
    drive_in(1'b1, 8'h0F, 8'h0F, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_in_ready", {31'd0, b0.in_ready}, 32'd1);
    check("rst_async_out_valid", {31'd0, b0.out_valid}, 32'd0);
    check("rst_async_y", {16'd0, b0.y}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (b0.out_valid === 1'b1) seen_valid = 1'b1;
    end
    check("rst_no_out_valid", {31'd0, seen_valid}, 32'd0);
    do_op(8'hF1, 8'h0F, 1'b0, y0, y1, lat);
    check("post_rst_y", {16'd0, y0}, 32'h0000FF1F);
    check("post_rst_latency", lat, 32'd10);

    // K=0 instance: approximate and exact modes agree and equal a*b.
    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      ep = sa * sb;
      do_op(sa, sb, 1'b0, y0, yk, lat);
      do_op(sa, sb, 1'b1, y0, y1, lat);
      check($sformatf("k0_%0d_exact", i), {16'd0, yk}, {16'd0, ep});
      check($sformatf("k0_%0d_approx", i), {16'd0, y1}, {16'd0, ep});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
